// File: rtl/pixel_writer_if.sv
// Pixel stream and framebuffer write port of the pixel writer.
//   pix_valid/pix_ready  : rasteriser -> writer handshake
//   pix_x/pix_y          : 10-bit unsigned coordinates
//   pix_color/pix_last   : colour and end-of-primitive flag
//   fb_we/fb_addr/fb_data: framebuffer write request, held until fb_ack
//   fb_ack               : framebuffer accepted the write this cycle
// The slave modport is the writer; the master modport is its environment.
interface pixel_writer_if #(
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned COLOR_W = 8
);
    logic               pix_valid;
    logic               pix_ready;
    logic [9:0]         pix_x;
    logic [9:0]         pix_y;
    logic [COLOR_W-1:0] pix_color;
    logic               pix_last;
    logic               fb_we;
    logic [ADDR_W-1:0]  fb_addr;
    logic [COLOR_W-1:0] fb_data;
    logic               fb_ack;

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_color, pix_last, fb_ack,
        output pix_ready, fb_we, fb_addr, fb_data
    );

    modport master (
        output pix_valid, pix_x, pix_y, pix_color, pix_last, fb_ack,
        input  pix_ready, fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/pixel_writer.sv
// pixel_writer: clips rasterised pixels to the visible frame, converts (x,y)
// to a linear framebuffer address and issues request/acknowledge writes.
// A small FIFO absorbs framebuffer stalls.
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   bus        : pixel stream in / framebuffer port out (pixel_writer_if.slave)
//   busy       : a pixel is in the stage register, the FIFO or in flight
//   done       : one-cycle pulse when the last pixel of a primitive retires
//   clip_count : saturating count of clipped pixels since reset
module pixel_writer #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned COLOR_W    = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    pixel_writer_if.slave    bus,
    output logic             busy,
    output logic             done,
    output logic [15:0]      clip_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // is_write=0 marks a clipped end-of-primitive: it retires without a write.
    typedef struct packed {
        logic               is_write;
        logic               last;
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } entry_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Enable for pix_ready so it stays low while reset is held.
    logic               ready_en_r;

    // Stage 1 register
    logic               stage_valid_r;
    logic               stage_clip_r;
    logic               stage_last_r;
    logic [ADDR_W-1:0]  stage_addr_r;
    logic [COLOR_W-1:0] stage_color_r;

    // Write queue
    entry_t             mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    // Issue FSM and registered outputs
    state_t             state_r;
    state_t             state_next_s;
    logic               fb_we_r;
    logic [ADDR_W-1:0]  fb_addr_r;
    logic [COLOR_W-1:0] fb_data_r;
    logic               done_r;
    logic [15:0]        clip_count_r;

    logic               fb_we_next_s;
    logic [ADDR_W-1:0]  fb_addr_next_s;
    logic [COLOR_W-1:0] fb_data_next_s;
    logic               done_next_s;
    logic               pop_s;

    logic [CNT_W-1:0]   occupancy_s;
    logic               pix_ready_s;
    logic               accept_s;
    logic               clip_s;
    logic [ADDR_W-1:0]  addr_s;
    logic               push_s;
    entry_t             push_entry_s;
    entry_t             head_s;
    logic               fifo_empty_s;

    // Input-side handshake, clipping and address arithmetic.
    // The stage register counts towards occupancy so a pixel accepted now
    // always finds a free FIFO slot on the next cycle.
    always_comb begin
        occupancy_s  = count_r + CNT_W'(stage_valid_r);
        pix_ready_s  = ready_en_r & (occupancy_s < CNT_W'(FIFO_DEPTH));
        accept_s     = bus.pix_valid & pix_ready_s;
        clip_s       = (32'(bus.pix_x) >= H_RES) | (32'(bus.pix_y) >= V_RES);
        addr_s       = (ADDR_W'(bus.pix_y) * ADDR_W'(H_RES)) + ADDR_W'(bus.pix_x);
        fifo_empty_s = (count_r == CNT_W'(0));
        head_s       = mem_r[rd_ptr_r];
        // Clipped pixels vanish unless they carry the end-of-primitive flag.
        push_s       = stage_valid_r & (~stage_clip_r | stage_last_r);
        push_entry_s.is_write = ~stage_clip_r;
        push_entry_s.last     = stage_last_r;
        push_entry_s.addr     = stage_addr_r;
        push_entry_s.color    = stage_color_r;
    end

    assign bus.pix_ready = pix_ready_s;

    // Ready enable: low in reset, high from the first clock after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Stage 1 register: captures one accepted pixel per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_valid_r <= 1'b0;
            stage_clip_r  <= 1'b0;
            stage_last_r  <= 1'b0;
            stage_addr_r  <= '0;
            stage_color_r <= '0;
        end else begin
            stage_valid_r <= accept_s;
            if (accept_s) begin
                stage_clip_r  <= clip_s;
                stage_last_r  <= bus.pix_last;
                stage_addr_r  <= addr_s;
                stage_color_r <= bus.pix_color;
            end
        end
    end

    // Clipped-pixel counter, saturating at all ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clip_count_r <= 16'h0000;
        end else if (stage_valid_r && stage_clip_r && (clip_count_r != 16'hFFFF)) begin
            clip_count_r <= clip_count_r + 16'h0001;
        end
    end

    // Write queue storage and pointers; pointers wrap at the power-of-two depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_entry_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue FSM next state and next output values.
    // The head entry stays queued while its write is in flight and is popped
    // only on acknowledge, so it keeps occupying a slot during a stall.
    always_comb begin
        state_next_s   = state_r;
        fb_we_next_s   = fb_we_r;
        fb_addr_next_s = fb_addr_r;
        fb_data_next_s = fb_data_r;
        done_next_s    = 1'b0;
        pop_s          = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    if (!head_s.is_write) begin
                        pop_s       = 1'b1;
                        done_next_s = head_s.last;
                    end else begin
                        fb_we_next_s   = 1'b1;
                        fb_addr_next_s = head_s.addr;
                        fb_data_next_s = head_s.color;
                        state_next_s   = ISSUE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (bus.fb_ack) begin
                    pop_s        = 1'b1;
                    fb_we_next_s = 1'b0;
                    done_next_s  = head_s.last;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            default: begin
                state_next_s = IDLE;
                fb_we_next_s = 1'b0;
            end
        endcase
    end

    // Issue FSM state and registered framebuffer outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            fb_we_r   <= 1'b0;
            fb_addr_r <= '0;
            fb_data_r <= '0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            fb_we_r   <= fb_we_next_s;
            fb_addr_r <= fb_addr_next_s;
            fb_data_r <= fb_data_next_s;
            done_r    <= done_next_s;
        end
    end

    assign bus.fb_we   = fb_we_r;
    assign bus.fb_addr = fb_addr_r;
    assign bus.fb_data = fb_data_r;
    assign done        = done_r;
    assign clip_count  = clip_count_r;
    assign busy        = stage_valid_r | ~fifo_empty_s | fb_we_r;

endmodule
